// File: rtl/ppu_resp_ctrl.sv
// Request/response controller between the EX stage and a multi-cycle posit datapath.
// Handles NaR and divide-by-zero shortcuts and a bounded wait for the datapath result.
module ppu_resp_ctrl #(
  parameter int unsigned              PPU_OP_WIDTH = 3,
  parameter logic [PPU_OP_WIDTH-1:0]  OP_DIV       = PPU_OP_WIDTH'(3),
  parameter int unsigned              TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ppu_valid_in,
  input  logic [31:0]             ppu_in1,
  input  logic [31:0]             ppu_in2,
  input  logic [PPU_OP_WIDTH-1:0] ppu_op,
  output logic [31:0]             ppu_out,
  output logic                    ppu_valid_o,
  output logic                    core_start_o,
  output logic [31:0]             core_in1_o,
  output logic [31:0]             core_in2_o,
  output logic [PPU_OP_WIDTH-1:0] core_op_o,
  input  logic [31:0]             core_out_i,
  input  logic                    core_done_i,
  output logic                    ppu_err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [31:0] NaR       = 32'h8000_0000;
  localparam logic [7:0]  CntLimit  = 8'(TIMEOUT - 1);

  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [31:0]             out_q, out_d;
  logic [31:0]             in1_q, in1_d;
  logic [31:0]             in2_q, in2_d;
  logic [PPU_OP_WIDTH-1:0] op_q, op_d;
  logic                    start_q, start_d;
  logic                    err_q, err_d;
  logic                    shortcut;

  assign shortcut = (ppu_in1 == NaR) || (ppu_in2 == NaR) ||
                    ((ppu_op == OP_DIV) && (ppu_in2 == 32'h0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    start_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (ppu_valid_in) begin
          in1_d = ppu_in1;
          in2_d = ppu_in2;
          op_d  = ppu_op;
          if (shortcut) begin
            out_d   = NaR;
            state_d = StResp;
          end else begin
            cnt_d   = 8'd0;
            start_d = 1'b1;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // Completion takes priority over an expiring timeout.
        if (core_done_i) begin
          out_d   = core_out_i;
          state_d = StResp;
        end else if (cnt_q == CntLimit) begin
          out_d   = NaR;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      out_q   <= 32'h0;
      in1_q   <= 32'h0;
      in2_q   <= 32'h0;
      op_q    <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign ppu_out      = out_q;
  assign ppu_valid_o  = (state_q == StResp);
  assign core_start_o = start_q;
  assign core_in1_o   = in1_q;
  assign core_in2_o   = in2_q;
  assign core_op_o    = op_q;
  assign ppu_err_o    = err_q;

endmodule

// File: tb/tb_ppu_resp_ctrl.sv
// Directed bench for ppu_resp_ctrl with TIMEOUT=8; every check is an immediate assertion.
module tb_ppu_resp_ctrl;

  logic        clk;
  logic        rst;
  logic        ppu_valid_in;
  logic [31:0] ppu_in1;
  logic [31:0] ppu_in2;
  logic [2:0]  ppu_op;
  logic [31:0] ppu_out;
  logic        ppu_valid_o;
  logic        core_start_o;
  logic [31:0] core_in1_o;
  logic [31:0] core_in2_o;
  logic [2:0]  core_op_o;
  logic [31:0] core_out_i;
  logic        core_done_i;
  logic        ppu_err_o;

  int checks;
  int failures;

  ppu_resp_ctrl #(
    .PPU_OP_WIDTH(3),
    .OP_DIV      (3'd3),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ppu_valid_in(ppu_valid_in),
    .ppu_in1     (ppu_in1),
    .ppu_in2     (ppu_in2),
    .ppu_op      (ppu_op),
    .ppu_out     (ppu_out),
    .ppu_valid_o (ppu_valid_o),
    .core_start_o(core_start_o),
    .core_in1_o  (core_in1_o),
    .core_in2_o  (core_in2_o),
    .core_op_o   (core_op_o),
    .core_out_i  (core_out_i),
    .core_done_i (core_done_i),
    .ppu_err_o   (ppu_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic s, input logic e);
    chk({tag, "_valid"}, {31'h0, ppu_valid_o}, {31'h0, v});
    chk({tag, "_start"}, {31'h0, core_start_o}, {31'h0, s});
    chk({tag, "_err"}, {31'h0, ppu_err_o}, {31'h0, e});
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    ppu_valid_in = 1'b0;
    ppu_in1      = 32'h0;
    ppu_in2      = 32'h0;
    ppu_op       = 3'd0;
    core_out_i   = 32'h0;
    core_done_i  = 1'b0;
    tick();
    tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_out", ppu_out, 32'h0);
    chk("reset_in1", core_in1_o, 32'h0);
    chk("reset_op", {29'h0, core_op_o}, 32'h0);
    rst = 1'b0;

    // Normal op: start at T+1, done at T+4, valid at T+5.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h4000_0000; ppu_in2 = 32'h4000_0000; ppu_op = 3'd0;
    tick();
    chk_ctl("norm_t1", 1'b0, 1'b1, 1'b0);
    chk("norm_in1", core_in1_o, 32'h4000_0000);
    chk("norm_in2", core_in2_o, 32'h4000_0000);
    ppu_in1 = 32'h1234_5678; ppu_op = 3'd5;  // must be ignored while busy
    tick();
    chk_ctl("norm_t2", 1'b0, 1'b0, 1'b0);
    chk("norm_hold_in1", core_in1_o, 32'h4000_0000);
    chk("norm_hold_op", {29'h0, core_op_o}, 32'h0);
    tick();
    tick();
    chk_ctl("norm_t4", 1'b0, 1'b0, 1'b0);
    core_done_i = 1'b1; core_out_i = 32'h4800_0000;
    tick();
    chk_ctl("norm_t5", 1'b1, 1'b0, 1'b0);
    chk("norm_out", ppu_out, 32'h4800_0000);
    core_done_i = 1'b0; core_out_i = 32'hdead_beef; ppu_valid_in = 1'b0;
    tick();
    chk_ctl("norm_t6", 1'b0, 1'b0, 1'b0);
    chk("norm_out_hold", ppu_out, 32'h4800_0000);

    // NaR shortcut on operand A.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h8000_0000; ppu_in2 = 32'h4000_0000; ppu_op = 3'd0;
    tick();
    chk_ctl("nar_t1", 1'b1, 1'b0, 1'b0);
    chk("nar_out", ppu_out, 32'h8000_0000);
    ppu_valid_in = 1'b0;
    tick();
    chk_ctl("nar_t2", 1'b0, 1'b0, 1'b0);

    // Divide by zero shortcut.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h4000_0000; ppu_in2 = 32'h0; ppu_op = 3'd3;
    tick();
    chk_ctl("div0_t1", 1'b1, 1'b0, 1'b0);
    chk("div0_out", ppu_out, 32'h8000_0000);
    chk("div0_op", {29'h0, core_op_o}, 32'd3);
    ppu_valid_in = 1'b0;
    tick();

    // Zero divisor with non-divide op goes to the core; done in T+1.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h3000_0000; ppu_in2 = 32'h0; ppu_op = 3'd1;
    tick();
    chk_ctl("mul0_t1", 1'b0, 1'b1, 1'b0);
    core_done_i = 1'b1; core_out_i = 32'h0000_0000;
    tick();
    chk_ctl("mul0_t2", 1'b1, 1'b0, 1'b0);
    chk("mul0_out", ppu_out, 32'h0);
    core_done_i = 1'b0; ppu_valid_in = 1'b0;
    tick();

    // Done coinciding with the timeout: done wins, err stays 0.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h4000_0000; ppu_in2 = 32'h5000_0000; ppu_op = 3'd2;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk_ctl("coin_t8", 1'b0, 1'b0, 1'b0);
    core_done_i = 1'b1; core_out_i = 32'h5555_0000;
    tick();
    chk_ctl("coin_t9", 1'b1, 1'b0, 1'b0);
    chk("coin_out", ppu_out, 32'h5555_0000);
    core_done_i = 1'b0; ppu_valid_in = 1'b0;
    tick();

    // Timeout: valid at T+9 with NaR and sticky err.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h4000_0000; ppu_in2 = 32'h4000_0000; ppu_op = 3'd0;
    tick();
    chk_ctl("to_t1", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk_ctl("to_t8", 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("to_t9", 1'b1, 1'b0, 1'b1);
    chk("to_out", ppu_out, 32'h8000_0000);
    ppu_valid_in = 1'b0;
    core_done_i = 1'b1; core_out_i = 32'h7777_7777;  // ignored outside BUSY
    tick();
    chk_ctl("to_t10", 1'b0, 1'b0, 1'b1);
    chk("to_out_hold", ppu_out, 32'h8000_0000);
    core_done_i = 1'b0;

    // Back-to-back with valid held high; err must remain set.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h4100_0000; ppu_in2 = 32'h4200_0000; ppu_op = 3'd1;
    tick();
    chk_ctl("b2b_a_t1", 1'b0, 1'b1, 1'b1);
    core_done_i = 1'b1; core_out_i = 32'h1111_0000;
    tick();
    chk_ctl("b2b_a_resp", 1'b1, 1'b0, 1'b1);
    chk("b2b_a_out", ppu_out, 32'h1111_0000);
    core_done_i = 1'b0;
    ppu_in1 = 32'h4300_0000; ppu_in2 = 32'h4400_0000; ppu_op = 3'd2;
    tick();
    chk_ctl("b2b_idle", 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("b2b_b_t1", 1'b0, 1'b1, 1'b1);
    chk("b2b_b_in1", core_in1_o, 32'h4300_0000);
    chk("b2b_b_op", {29'h0, core_op_o}, 32'd2);
    core_done_i = 1'b1; core_out_i = 32'h2222_0000;
    tick();
    chk_ctl("b2b_b_resp", 1'b1, 1'b0, 1'b1);
    chk("b2b_b_out", ppu_out, 32'h2222_0000);
    core_done_i = 1'b0; ppu_valid_in = 1'b0;
    tick();
    chk_ctl("b2b_end", 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("b2b_nodup", 1'b0, 1'b0, 1'b1);

    // Reset while busy aborts; later done is ignored.
    ppu_valid_in = 1'b1;
    ppu_in1 = 32'h4000_0000; ppu_in2 = 32'h4000_0000; ppu_op = 3'd0;
    tick();
    chk_ctl("rb_t1", 1'b0, 1'b1, 1'b1);
    ppu_valid_in = 1'b0;
    rst = 1'b1;
    core_done_i = 1'b1; core_out_i = 32'h9999_9999;  // reset wins
    tick();
    chk_ctl("rb_rst", 1'b0, 1'b0, 1'b0);
    chk("rb_out", ppu_out, 32'h0);
    chk("rb_in1", core_in1_o, 32'h0);
    chk("rb_in2", core_in2_o, 32'h0);
    rst = 1'b0;
    tick();
    chk_ctl("rb_done_ign", 1'b0, 1'b0, 1'b0);
    chk("rb_out2", ppu_out, 32'h0);
    core_done_i = 1'b0;
    tick();
    chk_ctl("rb_idle", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_resp_ctrl.md
PPU_RESP_CTRL -- requirements
Module: ppu_resp_ctrl

Interface
REQ-001 Parameter PPU_OP_WIDTH, default 3: width of ppu_op and core_op_o.
REQ-002 Parameter OP_DIV, default 3'd3: opcode of posit division.
REQ-003 Parameter TIMEOUT, default 64: maximum BUSY cycles to wait for core_done_i, range 2..255.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port ppu_valid_in, input, 1: EX-stage request level, held high until ppu_valid_o.
REQ-007 Port ppu_in1, input, 32: posit operand A.
REQ-008 Port ppu_in2, input, 32: posit operand B.
REQ-009 Port ppu_op, input, PPU_OP_WIDTH: operation code.
REQ-010 Port ppu_out, output, 32: result, registered.
REQ-011 Port ppu_valid_o, output, 1: one-cycle response pulse; ppu_out is valid in that cycle.
REQ-012 Port core_start_o, output, 1: one-cycle start pulse to the posit datapath.
REQ-013 Port core_in1_o, output, 32: latched operand A to the datapath.
REQ-014 Port core_in2_o, output, 32: latched operand B to the datapath.
REQ-015 Port core_op_o, output, PPU_OP_WIDTH: latched opcode to the datapath.
REQ-016 Port core_out_i, input, 32: datapath result, valid when core_done_i=1.
REQ-017 Port core_done_i, input, 1: datapath completion strobe.
REQ-018 Port ppu_err_o, output, 1: sticky timeout flag, cleared only by rst.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY, RESP.
REQ-020 In IDLE with ppu_valid_in=1, the block SHALL latch ppu_in1, ppu_in2 and ppu_op into core_in1_o, core_in2_o and core_op_o (accept cycle T).
REQ-021 Shortcut at accept: if either operand is 32'h8000_0000 (NaR), or ppu_op==OP_DIV with ppu_in2==0, the block SHALL load ppu_out=32'h8000_0000, enter RESP and not pulse core_start_o.
REQ-022 Any other accept SHALL enter BUSY and clear the timeout counter.
REQ-023 core_start_o SHALL be 1 only in the first BUSY cycle (T+1).
REQ-024 In BUSY, core_done_i=1 SHALL load ppu_out=core_out_i and enter RESP; done in that same T+1 cycle is legal.
REQ-025 In BUSY, when the counter reaches TIMEOUT without done, the block SHALL load ppu_out=32'h8000_0000, set ppu_err_o and enter RESP.
REQ-026 If done and the timeout coincide, done SHALL win and ppu_err_o SHALL stay unchanged.
REQ-027 RESP SHALL assert ppu_valid_o for exactly one cycle, then return to IDLE.
REQ-028 Latency: shortcut gives valid at T+1; core path gives valid at (done cycle + 1).
REQ-029 ppu_valid_in SHALL be ignored in BUSY and RESP; latched operands SHALL not change.
REQ-030 ppu_valid_in still high in the IDLE cycle after RESP SHALL be a new request (back-to-back issue), with no idle gap.
REQ-031 core_done_i outside BUSY SHALL be ignored.
REQ-032 ppu_out SHALL hold its last value outside RESP.
REQ-033 core_in1_o, core_in2_o and core_op_o SHALL hold their values until the next accept.

Reset
REQ-034 On rst=1 at a clock edge the block SHALL enter IDLE; ppu_out, core_in1_o, core_in2_o=0; core_op_o=0; ppu_valid_o, core_start_o, ppu_err_o=0; counter=0.
REQ-035 Reset during BUSY or RESP SHALL abort the request with no ppu_valid_o pulse; a later core_done_i SHALL be ignored.
REQ-036 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-037 Normal op: in1=32'h4000_0000, in2=32'h4000_0000, op=0; core done 3 cycles after start with core_out_i=32'h4800_0000 -> core_start_o at T+1, ppu_valid_o at T+5 with ppu_out=32'h4800_0000, err=0.
REQ-038 NaR shortcut: in1=32'h8000_0000 -> ppu_valid_o at T+1 with ppu_out=32'h8000_0000, no core_start_o.
REQ-039 Divide by zero: op=OP_DIV, in2=0 -> ppu_valid_o at T+1 with ppu_out=32'h8000_0000.
REQ-040 Timeout: core never done, TIMEOUT=8 -> ppu_valid_o with 32'h8000_0000 and ppu_err_o=1 sticky through the next successful op.
REQ-041 Back-to-back: ppu_valid_in held high across two requests -> two accepts, two core_start_o pulses, two single-cycle ppu_valid_o pulses, with no request dropped or duplicated.
REQ-042 Reset in BUSY: rst in BUSY, then core_done_i=1 -> no ppu_valid_o, all outputs 0, IDLE.
